// File: rtl/icm_get_req_arbiter_pkg.sv
// Shared definitions for the ICM get-request arbiter: head-field widths and
// output-stage state encoding.
package icm_get_req_arbiter_pkg;

  localparam int COUNT_MAX_LOG       = 16;
  localparam int MAX_REQ_TAG_NUM_LOG = 8;
  localparam int PHYSICAL_ADDR_WIDTH = 64;
  localparam int ICM_ADDR_WIDTH      = 24;

  // Head = two counts, a tag, a physical address and an ICM address.
  localparam int ICM_GET_HEAD_WIDTH  = COUNT_MAX_LOG * 2 + MAX_REQ_TAG_NUM_LOG +
                                       PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/icm_get_req_arbiter_if.sv
// Bundles the requester-side and cache-side handshakes of the ICM get-request arbiter.
interface icm_get_req_arbiter_if
  import icm_get_req_arbiter_pkg::*;
#(
  parameter int REQ_NUM     = 4,
  parameter int REQ_NUM_LOG = 2,
  parameter int HEAD_WIDTH  = ICM_GET_HEAD_WIDTH
);

  logic [REQ_NUM-1:0]            in_req_valid;
  logic [REQ_NUM*HEAD_WIDTH-1:0] in_req_head;
  logic [REQ_NUM-1:0]            in_req_ready;
  logic                          cache_get_req_valid;
  logic [HEAD_WIDTH-1:0]         cache_get_req_head;
  logic [REQ_NUM_LOG-1:0]        cache_get_req_src;
  logic                          cache_get_req_ready;

  // Environment side: requesters plus the cache.
  modport master (
    output in_req_valid, in_req_head, cache_get_req_ready,
    input  in_req_ready, cache_get_req_valid, cache_get_req_head, cache_get_req_src
  );

  // Arbiter side.
  modport slave (
    input  in_req_valid, in_req_head, cache_get_req_ready,
    output in_req_ready, cache_get_req_valid, cache_get_req_head, cache_get_req_src
  );

endinterface

// File: rtl/icm_get_req_arbiter_rr_grant.sv
// Combinational round-robin grant: first set request at or after rr_ptr,
// wrapping at REQ_NUM-1 (REQ_NUM need not be a power of two).
module icm_rr_grant #(
  parameter int REQ_NUM     = 4,
  parameter int REQ_NUM_LOG = 2
) (
  input  logic [REQ_NUM-1:0]     req,
  input  logic [REQ_NUM_LOG-1:0] rr_ptr,
  output logic [REQ_NUM-1:0]     grant,
  output logic [REQ_NUM_LOG-1:0] grant_idx
);

  logic                   found_s;
  int                     cand_s;
  logic [REQ_NUM_LOG-1:0] cand_idx_s;

  // Ascending search from rr_ptr; the first valid candidate wins.
  always_comb begin
    grant      = {REQ_NUM{1'b0}};
    grant_idx  = {REQ_NUM_LOG{1'b0}};
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = {REQ_NUM_LOG{1'b0}};
    for (int k = 0; k < REQ_NUM; k++) begin
      cand_s     = int'(rr_ptr) + k;
      cand_s     = (cand_s >= REQ_NUM) ? cand_s - REQ_NUM : cand_s;
      cand_idx_s = REQ_NUM_LOG'(cand_s);
      if (!found_s && req[cand_idx_s]) begin
        found_s           = 1'b1;
        grant[cand_idx_s] = 1'b1;
        grant_idx         = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/icm_get_req_arbiter.sv
// Round-robin arbiter sharing one ICM cache get-request port between REQ_NUM
// requesters, with a one-entry registered output stage and source tagging.
module icm_get_req_arbiter
  import icm_get_req_arbiter_pkg::*;
#(
  parameter int REQ_NUM     = 4,
  parameter int REQ_NUM_LOG = 2,
  parameter int HEAD_WIDTH  = ICM_GET_HEAD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  icm_get_req_arbiter_if.slave  bus
);

  logic [0:0]             out_state_r;
  logic [HEAD_WIDTH-1:0]  head_r;
  logic [REQ_NUM_LOG-1:0] src_r;
  logic [REQ_NUM_LOG-1:0] rr_ptr_r;

  logic [REQ_NUM-1:0]     grant_s;
  logic [REQ_NUM_LOG-1:0] grant_idx_s;
  logic                   load_s;
  logic [HEAD_WIDTH-1:0]  head_sel_s;
  logic [REQ_NUM_LOG-1:0] rr_ptr_nxt_s;

  icm_rr_grant #(
    .REQ_NUM     (REQ_NUM),
    .REQ_NUM_LOG (REQ_NUM_LOG)
  ) u_rr_grant (
    .req       (bus.in_req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Load when the stage is free or draining; masked in the reset cycle so no
  // handshake completes while rst is high.
  always_comb begin
    load_s = !rst && ((out_state_r == ST_EMPTY) || bus.cache_get_req_ready) &&
             (bus.in_req_valid != {REQ_NUM{1'b0}});
  end

  // Winner's head and the explicitly wrapped next pointer.
  always_comb begin
    head_sel_s = bus.in_req_head[grant_idx_s * HEAD_WIDTH +: HEAD_WIDTH];
    if (grant_idx_s == REQ_NUM_LOG'(REQ_NUM - 1)) begin
      rr_ptr_nxt_s = {REQ_NUM_LOG{1'b0}};
    end else begin
      rr_ptr_nxt_s = grant_idx_s + {{(REQ_NUM_LOG-1){1'b0}}, 1'b1};
    end
  end

  // Accept strobe back to the winning requester only.
  always_comb begin
    if (load_s) begin
      bus.in_req_ready = grant_s;
    end else begin
      bus.in_req_ready = {REQ_NUM{1'b0}};
    end
  end

  // Output stage and round-robin pointer; head/src freeze under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_r <= ST_EMPTY;
      head_r      <= {HEAD_WIDTH{1'b0}};
      src_r       <= {REQ_NUM_LOG{1'b0}};
      rr_ptr_r    <= {REQ_NUM_LOG{1'b0}};
    end else if (load_s) begin
      out_state_r <= ST_FULL;
      head_r      <= head_sel_s;
      src_r       <= grant_idx_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
    end else if (bus.cache_get_req_ready) begin
      out_state_r <= ST_EMPTY;
    end else begin
      out_state_r <= out_state_r;
    end
  end

  assign bus.cache_get_req_valid = (out_state_r == ST_FULL);
  assign bus.cache_get_req_head  = head_r;
  assign bus.cache_get_req_src   = src_r;

endmodule

// File: tb/tb_icm_get_req_arbiter.sv
// Self-checking bench for icm_get_req_arbiter: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_icm_get_req_arbiter;
  import icm_get_req_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int NL = 2;
  localparam int HW = ICM_GET_HEAD_WIDTH;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  icm_get_req_arbiter_if #(.REQ_NUM(N), .REQ_NUM_LOG(NL), .HEAD_WIDTH(HW)) bus ();

  icm_get_req_arbiter #(.REQ_NUM(N), .REQ_NUM_LOG(NL), .HEAD_WIDTH(HW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [HW-1:0] heads [N];
  logic          m_valid;
  logic [HW-1:0] m_head;
  logic [NL-1:0] m_src;
  int            m_ptr;
  logic [N-1:0]  exp_ready;
  logic [N-1:0]  obs_ready;

  // One clock: drive at negedge, sample ready before the edge, advance the model,
  // leave outputs ready to sample #1 after the edge.
  task automatic tick(input logic [N-1:0] v, input logic rdy, input logic r);
    int  g;
    bit  ld;
    @(negedge clk);
    bus.in_req_valid        = v;
    bus.cache_get_req_ready = rdy;
    rst                     = r;
    for (int i = 0; i < N; i++) bus.in_req_head[i*HW +: HW] = heads[i];
    #1;
    obs_ready = bus.in_req_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (g < 0 && v[c]) g = c;
    end
    ld = !r && (!m_valid || rdy) && (g >= 0);
    exp_ready = '0;
    if (ld) exp_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_head = '0; m_src = '0; m_ptr = 0;
    end else if (ld) begin
      m_valid = 1'b1; m_head = heads[g]; m_src = NL'(g); m_ptr = (g + 1) % N;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    heads[0] = {4{32'h1111_0000}};
    tick(4'b1111, 1'b1, 1'b1);
    tick(4'b1111, 1'b1, 1'b1);
    total_cnt++;
    if (obs_ready !== 4'b0000) $display("FAIL reset_ready: got %b exp 0000", obs_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.cache_get_req_valid !== 1'b0 || bus.cache_get_req_src !== 2'd0 ||
        bus.cache_get_req_head !== {HW{1'b0}})
      $display("FAIL reset_out: got v=%b src=%0d head=%h exp zeros",
               bus.cache_get_req_valid, bus.cache_get_req_src, bus.cache_get_req_head);
    else pass_cnt++;
  endtask

  task automatic test_single();
    heads[2] = {16{8'hA5}};
    tick(4'b0100, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b0100) $display("FAIL single_ready: got %b exp 0100", obs_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.cache_get_req_valid !== 1'b1 || bus.cache_get_req_src !== 2'd2 ||
        bus.cache_get_req_head !== {16{8'hA5}})
      $display("FAIL single_out: got v=%b src=%0d head=%h exp 1/2/a5..",
               bus.cache_get_req_valid, bus.cache_get_req_src, bus.cache_get_req_head);
    else pass_cnt++;
    // rr_ptr is now 3, so requester 3 wins with everyone valid.
    tick(4'b1111, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b1000) $display("FAIL single_ptr: got %b exp 1000", obs_ready);
    else pass_cnt++;
    tick(4'b0000, 1'b1, 1'b0);
    total_cnt++;
    if (bus.cache_get_req_valid !== 1'b0) $display("FAIL single_drain: got v=%b exp 0", bus.cache_get_req_valid);
    else pass_cnt++;
  endtask

  task automatic test_all_valid();
    for (int i = 0; i < N; i++) heads[i] = {4{$urandom}};
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] want;
      want = '0;
      want[k % N] = 1'b1;
      tick(4'b1111, 1'b1, 1'b0);
      total_cnt++;
      if (obs_ready !== want || obs_ready !== exp_ready)
        $display("FAIL all_valid_grant[%0d]: got %b exp %b", k, obs_ready, want);
      else pass_cnt++;
      total_cnt++;
      if (bus.cache_get_req_valid !== 1'b1 || bus.cache_get_req_src !== NL'(k % N) ||
          bus.cache_get_req_head !== heads[k % N])
        $display("FAIL all_valid_out[%0d]: got v=%b src=%0d exp 1/%0d",
                 k, bus.cache_get_req_valid, bus.cache_get_req_src, k % N);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [HW-1:0] held;
    tick(4'b0010, 1'b1, 1'b0);
    held = heads[1];
    for (int k = 0; k < 5; k++) begin
      heads[0] = {4{$urandom}};
      heads[3] = {4{$urandom}};
      tick(4'b1001, 1'b0, 1'b0);
      total_cnt++;
      if (obs_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b exp 0000", k, obs_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.cache_get_req_valid !== 1'b1 || bus.cache_get_req_src !== 2'd1 ||
          bus.cache_get_req_head !== held)
        $display("FAIL bp_hold[%0d]: got v=%b src=%0d exp 1/1 stable head",
                 k, bus.cache_get_req_valid, bus.cache_get_req_src);
      else pass_cnt++;
    end
    tick(4'b1001, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b1000) $display("FAIL bp_release: got %b exp 1000", obs_ready);
    else pass_cnt++;
    tick(4'b1001, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b0001) $display("FAIL bp_next: got %b exp 0001", obs_ready);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    tick(4'b0100, 1'b1, 1'b0);
    tick(4'b0011, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b0001) $display("FAIL wrap_first: got %b exp 0001", obs_ready);
    else pass_cnt++;
    tick(4'b0011, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b0010) $display("FAIL wrap_second: got %b exp 0010", obs_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    heads[2] = {4{$urandom}};
    tick(4'b0100, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b0100 || bus.cache_get_req_valid !== 1'b1 ||
        bus.cache_get_req_src !== 2'd2 || bus.cache_get_req_head !== heads[2])
      $display("FAIL b2b: got rdy=%b v=%b src=%0d exp 0100/1/2",
               obs_ready, bus.cache_get_req_valid, bus.cache_get_req_src);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick(4'b0001, 1'b1, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b1);
    total_cnt++;
    if (obs_ready !== 4'b0000 || bus.cache_get_req_valid !== 1'b0 ||
        bus.cache_get_req_src !== 2'd0 || bus.cache_get_req_head !== {HW{1'b0}})
      $display("FAIL reset_mid: got rdy=%b v=%b src=%0d exp 0000/0/0",
               obs_ready, bus.cache_get_req_valid, bus.cache_get_req_src);
    else pass_cnt++;
    tick(4'b1010, 1'b1, 1'b0);
    total_cnt++;
    if (obs_ready !== 4'b0010 || bus.cache_get_req_src !== 2'd1)
      $display("FAIL reset_mid_regrant: got rdy=%b src=%0d exp 0010/1",
               obs_ready, bus.cache_get_req_src);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) heads[i] = {$urandom, $urandom, $urandom, $urandom};
      tick(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      total_cnt++;
      if (obs_ready !== exp_ready) $display("FAIL rand_ready[%0d]: got %b exp %b", k, obs_ready, exp_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.cache_get_req_valid !== m_valid || bus.cache_get_req_src !== m_src ||
          bus.cache_get_req_head !== m_head)
        $display("FAIL rand_out[%0d]: got v=%b src=%0d exp v=%b src=%0d",
                 k, bus.cache_get_req_valid, bus.cache_get_req_src, m_valid, m_src);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    m_valid   = 1'b0;
    m_head    = '0;
    m_src     = '0;
    m_ptr     = 0;
    for (int i = 0; i < N; i++) heads[i] = '0;
    bus.in_req_valid        = '0;
    bus.in_req_head         = '0;
    bus.cache_get_req_ready = 1'b0;
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
